// File: rtl/set_score_if.sv
// Handshake and button bundle between the board/game FSM side and the SET SCORE controller.
interface set_score_if;
    logic       start;
    logic       btn_up;
    logic       btn_down;
    logic       btn_ok;
    logic [4:0] score;
    logic       show;
    logic       done;

    modport master (
        output start, btn_up, btn_down, btn_ok,
        input  score, show, done
    );

    modport slave (
        input  start, btn_up, btn_down, btn_ok,
        output score, show, done
    );
endinterface

// File: rtl/set_score_ctrl.sv
// SET SCORE menu controller: debounced up/down/ok buttons, saturating score with
// hold-to-repeat, and an IDLE/EDIT/DONE handshake with the game FSM.
module set_score_ctrl #(
    parameter int unsigned DEBOUNCE_CYC  = 1_000_000,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000,
    parameter int unsigned MIN_SCORE     = 1,
    parameter int unsigned MAX_SCORE     = 21,
    parameter int unsigned DEFAULT_SCORE = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    set_score_if.slave  bus
);

    localparam int unsigned DW      = $clog2(DEBOUNCE_CYC) + 1;
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RW      = $clog2(RPT_MAX) + 1;

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [4:0]    SMIN     = 5'(MIN_SCORE);
    localparam logic [4:0]    SMAX     = 5'(MAX_SCORE);
    localparam logic [4:0]    SDEF     = 5'(DEFAULT_SCORE);

    typedef enum logic [1:0] {StIdle, StEdit, StDone} state_e;

    state_e state_q, state_d;

    // Bit order everywhere: [0] up, [1] down, [2] ok
    logic [2:0]    raw;
    logic [2:0]    sync1_q, sync2_q, db_q, db_prev_q, rise;
    logic [DW-1:0] db_cnt_q [3];

    logic [RW-1:0] rpt_q, rpt_d;
    logic          phase_q, phase_d;
    logic          step_up, step_dn;
    logic [4:0]    score_q, score_d;
    logic          show_q, show_d, done_q, done_d;

    assign raw  = {bus.btn_ok, bus.btn_down, bus.btn_up};
    assign rise = db_q & ~db_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Repeat engine: phase 0 waits REPEAT_DELAY after the edge, phase 1 steps every period
    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        rpt_d   = rpt_q;
        phase_d = phase_q;
        if (state_q != StEdit || db_q[0] == db_q[1]) begin
            rpt_d   = '0;
            phase_d = 1'b0;
        end else if (rise[0] || rise[1]) begin
            step_up = rise[0];
            step_dn = rise[1];
            rpt_d   = '0;
            phase_d = 1'b0;
        end else if (rpt_q == (phase_q ? PER_LAST : DLY_LAST)) begin
            step_up = db_q[0];
            step_dn = db_q[1];
            rpt_d   = '0;
            phase_d = 1'b1;
        end else begin
            rpt_d = rpt_q + 1'b1;
        end
    end

    always_comb begin
        score_d = score_q;
        if (step_up && score_q != SMAX) begin
            score_d = score_q + 1'b1;
        end else if (step_dn && score_q != SMIN) begin
            score_d = score_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            show_q  <= 1'b0;
            done_q  <= 1'b0;
            score_q <= SDEF;
            rpt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            show_q  <= show_d;
            done_q  <= done_d;
            score_q <= score_d;
            rpt_q   <= rpt_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StEdit;
            StEdit:  if (rise[2])   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        show_d = (state_d == StEdit);
        done_d = (state_d == StDone);
    end

    assign bus.score = score_q;
    assign bus.show  = show_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_set_score_ctrl.sv
// Directed self-checking bench for set_score_ctrl with shortened debounce/repeat timing.
module tb_set_score_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   passes;
    int   fails;
    int   done_cnt;

    set_score_if bus ();

    set_score_ctrl #(
        .DEBOUNCE_CYC (4),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(5),
        .MIN_SCORE    (1),
        .MAX_SCORE    (21),
        .DEFAULT_SCORE(5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Clean press: debounced edge steps score on the 7th edge, then release and settle
    task automatic press_up();
        bus.btn_up = 1'b1;
        tick(7);
        bus.btn_up = 1'b0;
        tick(8);
    endtask

    task automatic press_down();
        bus.btn_down = 1'b1;
        tick(7);
        bus.btn_down = 1'b0;
        tick(8);
    endtask

    initial begin
        checks   = 0;
        passes   = 0;
        fails    = 0;
        done_cnt = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.btn_ok   = 1'b0;

        tick(3);
        chk("rst_score", 32'(bus.score), 32'd5);
        chk("rst_show", 32'(bus.show), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_show", 32'(bus.show), 32'd0);

        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        chk("start_show", 32'(bus.show), 32'd1);

        // Single clean press held 6 cycles
        bus.btn_up = 1'b1;
        tick(6);
        bus.btn_up = 1'b0;
        chk("press_early", 32'(bus.score), 32'd5);
        tick(1);
        chk("press_step", 32'(bus.score), 32'd6);
        tick(12);
        chk("press_once", 32'(bus.score), 32'd6);

        // 3-cycle glitch never reaches the debounced level
        bus.btn_up = 1'b1;
        tick(3);
        bus.btn_up = 1'b0;
        tick(12);
        chk("glitch", 32'(bus.score), 32'd6);

        // Hold-to-repeat: edge step, +20, then every 5
        bus.btn_up = 1'b1;
        tick(7);
        chk("rpt_edge", 32'(bus.score), 32'd7);
        tick(19);
        chk("rpt_pre_delay", 32'(bus.score), 32'd7);
        tick(1);
        chk("rpt_delay", 32'(bus.score), 32'd8);
        for (int k = 9; k <= 11; k++) begin
            tick(4);
            chk("rpt_pre_period", 32'(bus.score), 32'(k - 1));
            tick(1);
            chk("rpt_period", 32'(bus.score), 32'(k));
        end
        tick(5);
        chk("rpt_12", 32'(bus.score), 32'd12);
        // Release now: debounced level still high when the next period expires
        bus.btn_up = 1'b0;
        tick(5);
        chk("rpt_last", 32'(bus.score), 32'd13);
        tick(30);
        chk("rpt_stop", 32'(bus.score), 32'd13);

        for (int k = 0; k < 8; k++) press_up();
        chk("reach_max", 32'(bus.score), 32'd21);
        press_up();
        chk("sat_max", 32'(bus.score), 32'd21);

        for (int k = 0; k < 20; k++) press_down();
        chk("reach_min", 32'(bus.score), 32'd1);
        press_down();
        chk("sat_min", 32'(bus.score), 32'd1);

        // Both pressed together
        bus.btn_up   = 1'b1;
        bus.btn_down = 1'b1;
        tick(40);
        chk("both_hold", 32'(bus.score), 32'd1);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        tick(10);
        chk("both_release", 32'(bus.score), 32'd1);

        // Second button's edge ignored, and held first button stops repeating
        bus.btn_up = 1'b1;
        tick(7);
        chk("second_first", 32'(bus.score), 32'd2);
        bus.btn_down = 1'b1;
        tick(40);
        chk("second_ignored", 32'(bus.score), 32'd2);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        tick(10);
        chk("second_release", 32'(bus.score), 32'd2);

        // Confirm with OK
        chk("pre_ok_done_cnt", 32'(done_cnt), 32'd0);
        bus.btn_ok = 1'b1;
        tick(6);
        chk("ok_wait_show", 32'(bus.show), 32'd1);
        chk("ok_wait_done", 32'(bus.done), 32'd0);
        tick(1);
        chk("ok_done", 32'(bus.done), 32'd1);
        chk("ok_show_off", 32'(bus.show), 32'd0);
        tick(1);
        chk("ok_done_off", 32'(bus.done), 32'd0);
        chk("ok_idle_show", 32'(bus.show), 32'd0);

        // Resume from confirmed value with OK still held: no confirm until repress
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        chk("resume_show", 32'(bus.show), 32'd1);
        chk("resume_score", 32'(bus.score), 32'd2);
        tick(10);
        chk("ok_held_show", 32'(bus.show), 32'd1);
        bus.btn_ok = 1'b0;
        tick(10);
        chk("ok_held_done_cnt", 32'(done_cnt), 32'd1);

        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        chk("start_in_edit", 32'(bus.show), 32'd1);

        // Reset mid-hold at score 9
        for (int k = 0; k < 7; k++) press_up();
        chk("reach_9", 32'(bus.score), 32'd9);
        bus.btn_up = 1'b1;
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("midrst_score", 32'(bus.score), 32'd5);
        chk("midrst_show", 32'(bus.show), 32'd0);
        tick(3);
        rst_n = 1'b1;
        bus.btn_up = 1'b0;
        tick(10);
        chk("postrst_score", 32'(bus.score), 32'd5);
        chk("postrst_done_cnt", 32'(done_cnt), 32'd1);

        // OK edge in IDLE ignored
        bus.btn_ok = 1'b1;
        tick(10);
        bus.btn_ok = 1'b0;
        tick(10);
        chk("idle_ok_show", 32'(bus.show), 32'd0);
        chk("idle_ok_done_cnt", 32'(done_cnt), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
